// File: rtl/fp2bcd_pkg.sv
// fp2bcd_pkg: shared state type and constants for the float-to-BCD converter.
// FP2BCD_FRAC_EN enables the fractional-digit stage.
package fp2bcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    DABBLE = 3'd2,
    FRAC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int INT_DIGITS  = 10;
  localparam int FRAC_DIGITS = 4;
  localparam int FRAC_W      = 37;
  localparam int EXP_BIAS    = 127;
  localparam int INT_W       = 32;

endpackage

// File: rtl/fp_to_bcd_seq_dabble_digit.sv
// dabble_digit: one BCD digit correction cell for shift-and-add-3.
// Adds 3 when the digit is 5 or more so the next shift carries correctly.
module dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/fp_to_bcd_seq.sv
// fp_to_bcd_seq: sequential IEEE-754 single to packed BCD converter.
// FP2BCD_FRAC_EN adds four truncated fractional digits.
module fp_to_bcd_seq
  import fp2bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [39:0] int_bcd,
  output logic [15:0] frac_bcd,
  output logic        is_nan,
  output logic        is_inf,
  output logic        ovf
);

  localparam int         FIX_W  = INT_W + FRAC_W;
  localparam logic [7:0] EXP_LO = 8'(EXP_BIAS - 14);
  localparam logic [7:0] EXP_HI = 8'(EXP_BIAS + INT_W);

  state_e      state;
  logic [4:0]  cnt;
  logic [31:0] op;
  logic [31:0] bin;
  logic [39:0] adj;
  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic [23:0] mant;
  logic [5:0]  sh;
  logic        special;
  logic        flush;
  logic        big;
  logic [31:0] ipart;

  assign exp_f   = op[30:23];
  assign man_f   = op[22:0];
  assign mant    = {1'b1, man_f};
  assign special = exp_f == 8'hFF;
  assign flush   = exp_f < EXP_LO;
  assign big     = exp_f >= EXP_HI;
  // shift places the value into a 32.37 fixed-point frame
  assign sh      = 6'(exp_f - EXP_LO);
  assign ipart   = INT_W'(({{(FIX_W-24){1'b0}}, mant} << sh) >> FRAC_W);

`ifdef FP2BCD_FRAC_EN
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] fpart;
  logic [FRAC_W+3:0] f10;

  assign fpart = FRAC_W'({{(FIX_W-24){1'b0}}, mant} << sh);
  assign f10   = ({4'b0, frac} << 3) + ({4'b0, frac} << 1);
`else
  assign frac_bcd = '0;
`endif

  for (genvar i = 0; i < INT_DIGITS; i++) begin : g_dig
    dabble_digit u_dig (
      .d (int_bcd[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      bin     <= '0;
      sign    <= 1'b0;
      int_bcd <= '0;
      is_nan  <= 1'b0;
      is_inf  <= 1'b0;
      ovf     <= 1'b0;
`ifdef FP2BCD_FRAC_EN
      frac     <= '0;
      frac_bcd <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= fp_in;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sign    <= op[31];
          int_bcd <= '0;
          is_nan  <= special && (man_f != '0);
          is_inf  <= special && (man_f == '0);
          ovf     <= big && !special;
          cnt     <= '0;
          bin     <= ipart;
`ifdef FP2BCD_FRAC_EN
          frac     <= fpart;
          frac_bcd <= '0;
`endif
          if (special || big || flush) state <= DONE;
          else state <= DABBLE;
        end
        DABBLE: begin
          int_bcd <= 40'({adj, bin[31]});
          bin     <= bin << 1;
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd31) begin
`ifdef FP2BCD_FRAC_EN
            state <= FRAC;
`else
            state <= DONE;
`endif
          end
        end
`ifdef FP2BCD_FRAC_EN
        FRAC: begin
          frac_bcd <= {frac_bcd[11:0], f10[FRAC_W+3:FRAC_W]};
          frac     <= f10[FRAC_W-1:0];
          cnt      <= cnt + 5'd1;
          if (cnt == 5'(FRAC_DIGITS - 1)) state <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_bcd_seq.sv
// tb_fp_to_bcd_seq: self-checking bench for fp_to_bcd_seq.
// Reference model decodes the float with integer division and modulo.
module tb_fp_to_bcd_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] fp_in     = '0;
  logic        in_ready;
  logic        out_valid;
  logic        sign;
  logic        is_nan;
  logic        is_inf;
  logic        ovf;
  logic [39:0] int_bcd;
  logic [15:0] frac_bcd;

  int vectors     = 0;
  int miscompares = 0;

`ifdef FP2BCD_FRAC_EN
  localparam int         LAT_N   = 38;
  localparam logic [15:0] FB_MASK = 16'hFFFF;
`else
  localparam int         LAT_N   = 34;
  localparam logic [15:0] FB_MASK = 16'h0000;
`endif

  always #5 clk = ~clk;

  fp_to_bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .int_bcd   (int_bcd),
    .frac_bcd  (frac_bcd),
    .is_nan    (is_nan),
    .is_inf    (is_inf),
    .ovf       (ovf)
  );

  // flags packed as {sign, nan, inf, ovf}
  function automatic void model(
    input  logic [31:0] x,
    output logic [39:0] ib,
    output logic [15:0] fb,
    output logic [3:0]  fl,
    output int          lat
  );
    int     e;
    int     k;
    longint mant;
    longint ival;
    longint num;
    longint mask;
    longint one;
    one  = 1;
    ib   = '0;
    fb   = '0;
    fl   = {x[31], 3'b000};
    lat  = 2;
    mant = 0;
    e    = int'(x[30:23]) - 127;
    if (x[30:23] == 8'hFF) begin
      fl[2] = x[22:0] != '0;
      fl[1] = x[22:0] == '0;
    end else if (x[30:23] == 8'h00 || e <= -15) begin
      lat = 2;
    end else if (e >= 32) begin
      fl[0] = 1'b1;
    end else begin
      mant[23:0] = {1'b1, x[22:0]};
      if (e >= 23) begin
        ival = mant << (e - 23);
        k    = 0;
        num  = 0;
        mask = 0;
      end else begin
        k    = 23 - e;
        ival = mant >> k;
        mask = (one << k) - 1;
        num  = mant & mask;
      end
      for (int i = 0; i < 10; i++) begin
        ib[4*i +: 4] = 4'(ival % 10);
        ival = ival / 10;
      end
      for (int d = 0; d < 4; d++) begin
        num = num * 10;
        fb  = {fb[11:0], 4'(num >> k)};
        num = num & mask;
      end
      fb  = fb & FB_MASK;
      lat = LAT_N;
    end
  endfunction

  task automatic run_op(input logic [31:0] x, output int lat);
    @(negedge clk);
    fp_in    = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_in    = $urandom();
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h want 0",
               {out_valid, sign, is_nan, is_inf, ovf, int_bcd, frac_bcd});
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] xs  [7] = '{32'h3F800000, 32'hC2F6E979, 32'h4F7FFFFF,
                            32'h4F800000, 32'h7FC00000, 32'hFF800000,
                            32'h38D1B717};
    logic [39:0] ibs [7] = '{40'h1, 40'h123, 40'h4294967040,
                            40'h0, 40'h0, 40'h0, 40'h0};
    logic [15:0] fbs [7] = '{16'h0, 16'h4560, 16'h0, 16'h0,
                            16'h0, 16'h0, 16'h0};
    logic [3:0]  fls [7] = '{4'b0000, 4'b1000, 4'b0000, 4'b0001,
                            4'b0100, 4'b1010, 4'b0000};
    int          lts [7] = '{LAT_N, LAT_N, LAT_N, 2, 2, 2, LAT_N};
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(xs[i], lat);
      vectors++;
      if (int_bcd !== ibs[i]) begin
        miscompares++;
        $display("FAIL dir_int %h: got %h want %h", xs[i], int_bcd, ibs[i]);
      end
      vectors++;
      if (frac_bcd !== (fbs[i] & FB_MASK)) begin
        miscompares++;
        $display("FAIL dir_frac %h: got %h want %h",
                 xs[i], frac_bcd, fbs[i] & FB_MASK);
      end
      vectors++;
      if ({sign, is_nan, is_inf, ovf} !== fls[i]) begin
        miscompares++;
        $display("FAIL dir_flags %h: got %b want %b",
                 xs[i], {sign, is_nan, is_inf, ovf}, fls[i]);
      end
      vectors++;
      if (lat !== lts[i]) begin
        miscompares++;
        $display("FAIL dir_lat %h: got %0d want %0d", xs[i], lat, lts[i]);
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [39:0] ib;
    logic [15:0] fb;
    logic [3:0]  fl;
    logic [59:0] snap;
    int          lat;
    int          elat;
    model(32'h42F6E979, ib, fb, fl, elat);
    run_op(32'h42F6E979, lat);
    snap = {fl, ib, fb};
    vectors++;
    if ({sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== snap || lat !== elat) begin
      miscompares++;
      $display("FAIL stall_result: got %h lat %0d want %h lat %0d",
               {sign, is_nan, is_inf, ovf, int_bcd, frac_bcd}, lat, snap, elat);
    end
    in_valid = 1'b1;
    fp_in    = 32'h3F800000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== snap ||
          out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold c%0d: got %h v%b r%b want %h v1 r0", c,
                 {sign, is_nan, is_inf, ovf, int_bcd, frac_bcd},
                 out_valid, in_ready, snap);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hs_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_idle: got v%b r%b want v0 r1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (int_bcd !== 40'h1 || frac_bcd !== 16'h0 || lat !== LAT_N) begin
      miscompares++;
      $display("FAIL stall_next: got %h.%h lat %0d want 1.0 lat %0d",
               int_bcd, frac_bcd, lat, LAT_N);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [39:0] ib;
    logic [15:0] fb;
    logic [3:0]  fl;
    int          lat;
    int          elat;
    @(negedge clk);
    fp_in    = 32'h4F7FFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== '0 ||
        in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset: got %h r%b want 0 r1",
               {out_valid, sign, is_nan, is_inf, ovf, int_bcd, frac_bcd}, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(32'hC2F6E979, ib, fb, fl, elat);
    run_op(32'hC2F6E979, lat);
    vectors++;
    if ({sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== {fl, ib, fb} ||
        lat !== elat) begin
      miscompares++;
      $display("FAIL midreset_next: got %h lat %0d want %h lat %0d",
               {sign, is_nan, is_inf, ovf, int_bcd, frac_bcd}, lat,
               {fl, ib, fb}, elat);
    end
    release_out();
  endtask

  task automatic test_random(input int n);
    logic [31:0] x;
    logic [39:0] ib;
    logic [15:0] fb;
    logic [3:0]  fl;
    int          lat;
    int          elat;
    for (int i = 0; i < n; i++) begin
      x = $urandom();
      if ($urandom_range(3) != 0) x[30:23] = 8'($urandom_range(100, 165));
      model(x, ib, fb, fl, elat);
      run_op(x, lat);
      vectors++;
      if ({sign, is_nan, is_inf, ovf, int_bcd, frac_bcd} !== {fl, ib, fb} ||
          lat !== elat) begin
        miscompares++;
        $display("FAIL rand %h: got %h lat %0d want %h lat %0d", x,
                 {sign, is_nan, is_inf, ovf, int_bcd, frac_bcd}, lat,
                 {fl, ib, fb}, elat);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_to_bcd_seq.md
FP_TO_BCD_SEQ -- requirements
Module: fp_to_bcd_seq

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low; single clock domain.
REQ-003 SHALL: in_valid  input  1  fp_in holds a valid operand.
REQ-004 SHALL: in_ready  output  1  block can accept an operand.
REQ-005 SHALL: fp_in  input  32  IEEE-754 single, typically a product from the FP multiplier.
REQ-006 SHALL: out_valid  output  1  result fields valid.
REQ-007 SHALL: out_ready  input  1  consumer accepts the result.
REQ-008 SHALL: sign  output  1  copy of fp_in[31].
REQ-009 SHALL: int_bcd  output  40  integer part, 10 packed BCD digits, MS digit in [39:36].
REQ-010 SHALL: frac_bcd  output  16  first 4 fractional digits, truncated, MS digit in [15:12].
REQ-011 SHALL: is_nan / is_inf / ovf  output  1 each  NaN; infinity; finite with |x| >= 2^32.

Function
REQ-012 SHALL: handshake: accept when in_valid && in_ready; in_ready = 1 only in IDLE.
REQ-013 SHALL: FSM states are IDLE, ALIGN, DABBLE, FRAC, DONE.
REQ-014 SHALL: the operand is latched on acceptance, then IDLE -> ALIGN.
REQ-015 SHALL: ALIGN unpacks E = exp-127 and mantissa {1,m}, then shifts into a 32.37 fixed-point register.
REQ-016 SHALL: exp==0 (zero/denormal) or E <= -15 yield int 0 and frac 0.
REQ-017 SHALL: in ALIGN, exp==255 sets is_nan (m!=0) or is_inf (m==0), E >= 32 sets ovf; each goes directly ALIGN -> DONE with digits 0.
REQ-018 SHALL: DABBLE runs exactly 32 shift-and-add-3 iterations on the integer part, counted by a 5-bit counter; DABBLE -> FRAC at the end.
REQ-019 SHALL: FRAC runs exactly 4 iterations of fraction*10 (f<<3 + f<<1); each iteration's 4 bits above bit 37 form the next digit; FRAC -> DONE at the end.
REQ-020 SHALL: normal latency is out_valid high on the 38th rising edge after the accepting edge; special or flush-to-zero cases take 2 edges.
REQ-021 SHALL: all results are truncated toward zero, with no rounding.
REQ-022 SHALL: in DONE, out_valid = 1 and every output holds stable until out_ready; DONE -> IDLE on out_valid && out_ready.
REQ-023 SHALL: in_ready stays 0 in the cycle of the DONE handshake, so there is no same-cycle re-accept.
REQ-024 SHALL: in_valid is ignored outside IDLE, and fp_in changes after acceptance have no effect.

Reset
REQ-025 SHALL: rst_n low forces IDLE at any time, including mid-DABBLE/FRAC; the in-flight operand is discarded.
REQ-026 SHALL: under reset, every output other than in_ready is 0, including out_valid, sign, int_bcd, frac_bcd and all flags.
REQ-027 SHALL: under reset, in_ready = 1 once in IDLE.

Configuration
REQ-028 SHALL: the feature macro is FP2BCD_FRAC_EN.
REQ-029 SHALL: when FP2BCD_FRAC_EN is defined, the FRAC state and 37-bit fraction datapath exist as specified.
REQ-030 SHALL: when FP2BCD_FRAC_EN is undefined, FRAC is removed, frac_bcd is tied to 0, DABBLE -> DONE, and normal latency is 34 edges.

Structure
REQ-031 SHALL: package fp2bcd_pkg holds the state enum, INT_DIGITS=10, FRAC_DIGITS=4, FRAC_W=37 and EXP_BIAS=127.
REQ-032 SHALL: sub-module dabble_digit, a 4-bit "add 3 if >= 5" cell, is instantiated 10 times.

Verification
REQ-033 SHALL: 0x3F800000 -> int_bcd=0x0000000001, frac_bcd=0x0000, sign 0, flags 0, out_valid at edge 38.
REQ-034 SHALL: 0xC2F6E979 -> sign 1, int_bcd=0x0000000123, frac_bcd=0x4560.
REQ-035 SHALL: 0x4F7FFFFF -> int_bcd=0x4294967040, ovf 0; 0x4F800000 -> ovf 1, digits 0, out_valid at edge 2.
REQ-036 SHALL: 0x7FC00000 -> is_nan 1; 0xFF800000 -> is_inf 1, sign 1; 0x38D1B717 -> frac_bcd=0x0000.
REQ-037 SHALL: with out_ready held 0 for 10 cycles after DONE, the outputs stay stable and in_ready stays 0; the handshake then returns the block to IDLE.
REQ-038 SHALL: rst_n pulsed low at iteration 15 of DABBLE -> immediate IDLE with all outputs 0, and the next operand converts correctly.
